mem_store_unit: RTL and testbench

//  Write-side data path for the multicycle CPU's data memory.
//  - Takes a store request from the control FSM: address, register data, size.
//  - Aligns the data onto byte lanes and generates byte enables.
//  - Runs a req/ack write handshake with the data memory and reports done/error.
//  - Counterpart of the read-side memory data register: that block latches data coming out of memory; this one drives data into memory.

---
 rtl/cpu_defs.sv | 20 ++
 rtl/store_align.sv | 39 +++
 rtl/mem_store_unit.sv | 103 ++++++++++
 tb/tb_mem_store_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle CPU data path: store size encodings
// and the state encoding of the store unit.
package cpu_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } store_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane steering for stores: replicates the source data across
// byte lanes, builds little-endian byte enables and flags misaligned requests.
module store_align
  import cpu_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  // Replicating the data lets the byte enables alone select the target lanes.
  always_comb begin
    wdata    = data;
    be       = 4'b0000;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        wdata    = {2{data[15:0]}};
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Write-side data path for the data memory: aligns a store onto byte lanes
// and runs the req/ack write handshake, reporting done/error to control.
module mem_store_unit
  import cpu_defs::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_start,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  store_state_e state;
  logic [7:0]   wait_cnt;
  logic [31:0]  al_wdata;
  logic [3:0]   al_be;
  logic         al_misalign;

  store_align u_align (
    .addr_lo  (st_addr[1:0]),
    .size     (st_size),
    .data     (st_data),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign)
  );

  assign mem_we = mem_req;

  // DONE behaves like IDLE for new requests so back-to-back stores lose no cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (st_start && al_misalign) begin
            state   <= ST_DONE;
            st_busy <= 1'b1;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else if (st_start) begin
            state     <= ST_REQ;
            st_busy   <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= word_addr(st_addr);
            mem_wdata <= al_wdata;
            mem_be    <= al_be;
            wait_cnt  <= 8'd0;
          end else begin
            state   <= ST_IDLE;
            st_busy <= 1'b0;
          end
        end
        ST_REQ: begin
          // An ack on the timeout edge still counts as a successful write.
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            st_done <= 1'b1;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          st_busy <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed self-checking bench for mem_store_unit: lane steering, handshake
// latency, timeout, busy/idle filtering and mid-transfer reset.
module tb_mem_store_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_start;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_start  (st_start),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a store for one edge, then scrambles the inputs to prove capture.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    st_start = 1'b1;
    tick();
    st_start = 1'b0;
    st_addr  = $urandom;
    st_data  = $urandom;
    st_size  = 2'($urandom);
  endtask

  // Runs one store, acking in REQ cycle waits+1, and checks lanes, stability and done.
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int waits, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic exp_err, input int exp_req);
    int req_cycles;
    req_cycles = 0;
    applyStimulus(a, d, sz);
    for (int c = 0; c < 20; c++) begin
      if (mem_req !== 1'b1) break;
      req_cycles++;
      checkOutput({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      checkOutput({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      checkOutput({tag, "_wdata"}, mem_wdata, exp_wd);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
      mem_ack = (req_cycles == waits + 1);
      tick();
      mem_ack = 1'b0;
    end
    checkOutput({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
    checkOutput({tag, "_done"}, 32'(st_done), 32'd1);
    checkOutput({tag, "_err"}, 32'(st_err), 32'(exp_err));
    checkOutput({tag, "_req_low"}, 32'(mem_req), 32'd0);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(st_done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(st_busy), 32'd0);
  endtask

  initial begin
    int bursts;
    int dones;
    reset    = 1'b1;
    st_start = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    mem_ack  = 1'b0;
    tick();
    tick();
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(st_busy), 32'd0);
    checkOutput("rst_done", 32'(st_done), 32'd0);
    checkOutput("rst_err", 32'(st_err), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_be", 32'(mem_be), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] lane steering and handshake latency");
    run_store("word",     32'h100, 32'hDEADBEEF, SIZE_WORD, 0,   4'b1111, 32'hDEADBEEF, 1'b0, 1);
    run_store("byte3",    32'h203, 32'h000000A5, SIZE_BYTE, 3,   4'b1000, 32'hA5A5A5A5, 1'b0, 4);
    run_store("byte1",    32'h201, 32'hFFFFFF77, SIZE_BYTE, 1,   4'b0010, 32'h77777777, 1'b0, 2);
    run_store("half_hi",  32'h102, 32'h00001234, SIZE_HALF, 0,   4'b1100, 32'h12341234, 1'b0, 1);
    run_store("half_lo",  32'h100, 32'hABCD5678, SIZE_HALF, 2,   4'b0011, 32'h56785678, 1'b0, 3);
    run_store("half_mis", 32'h101, 32'h00001234, SIZE_HALF, 0,   4'b0000, 32'h0,        1'b1, 0);
    run_store("word_mis", 32'h102, 32'h11111111, SIZE_WORD, 0,   4'b0000, 32'h0,        1'b1, 0);
    run_store("size_ill", 32'h100, 32'h22222222, SIZE_ILL,  0,   4'b0000, 32'h0,        1'b1, 0);
    run_store("timeout",  32'h180, 32'h0BADF00D, SIZE_WORD, 100, 4'b1111, 32'h0BADF00D, 1'b1, 4);

    $display("[TB] start while busy and ack while idle");
    applyStimulus(32'h300, 32'h11223344, SIZE_WORD);
    st_start = 1'b1;
    st_addr  = 32'h500;
    st_data  = 32'h99999999;
    st_size  = SIZE_WORD;
    checkOutput("busy_addr1", mem_addr, 32'h300);
    tick();
    checkOutput("busy_addr2", mem_addr, 32'h300);
    checkOutput("busy_wdata2", mem_wdata, 32'h11223344);
    tick();
    st_start = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("busy_done", 32'(st_done), 32'd1);
    tick();
    bursts = 0;
    dones  = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'b1;
      if (mem_req) bursts++;
      if (st_done) dones++;
      tick();
    end
    mem_ack = 1'b0;
    checkOutput("idle_ack_req", 32'(bursts), 32'd0);
    checkOutput("idle_ack_done", 32'(dones), 32'd0);

    $display("[TB] back-to-back stores");
    applyStimulus(32'h600, 32'hCAFEF00D, SIZE_WORD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("b2b_done1", 32'(st_done), 32'd1);
    applyStimulus(32'h604, 32'h0000BEEF, SIZE_HALF);
    checkOutput("b2b_req2", 32'(mem_req), 32'd1);
    checkOutput("b2b_addr2", mem_addr, 32'h604);
    checkOutput("b2b_be2", 32'(mem_be), 32'h3);
    checkOutput("b2b_wdata2", mem_wdata, 32'hBEEFBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("b2b_done2", 32'(st_done), 32'd1);
    tick();

    $display("[TB] reset during REQ");
    applyStimulus(32'h400, 32'h87654321, SIZE_WORD);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_busy", 32'(st_busy), 32'd0);
    checkOutput("mid_rst_be", 32'(mem_be), 32'd0);
    checkOutput("mid_rst_addr", mem_addr, 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (st_done) dones++;
      tick();
    end
    checkOutput("mid_rst_no_done", 32'(dones), 32'd0);
    run_store("post_rst", 32'h700, 32'h0000005A, SIZE_BYTE, 0, 4'b0001, 32'h5A5A5A5A, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
